timer_config_loader: RTL and testbench



---
 rtl/timer_config_loader.sv | 220 ++++++++++++++++++++++
 tb/tb_timer_config_loader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_config_loader.sv
// timer_config_loader: collects two BCD digits from switches, loads them into
// the countdown timer with an active-low config pulse, starts it with an
// active-low game pulse, and reports expiry when the timer stops at 00.
module timer_config_loader #(
    parameter int PULSE_CYCLES = 4,
    parameter int MAX_DIGIT    = 9
) (
    input  logic       clk_50Mhz,
    input  logic       reset,
    input  logic [3:0] digit_sw,
    input  logic       enter_bt,
    input  logic       start_bt,
    input  logic [3:0] timer_dec,
    input  logic [3:0] timer_sec,
    input  logic       timer_running,
    output logic [3:0] config_dec,
    output logic [3:0] config_sec,
    output logic       config_bt,
    output logic       game_bt,
    output logic [2:0] state_code,
    output logic       digit_err,
    output logic       expired
);

    typedef enum logic [2:0] {
        ST_ENTER_DEC = 3'd0,
        ST_ENTER_SEC = 3'd1,
        ST_LOAD      = 3'd2,
        ST_ARMED     = 3'd3,
        ST_START     = 3'd4,
        ST_WAIT_RUN  = 3'd5,
        ST_RUNNING   = 3'd6,
        ST_EXPIRED   = 3'd7
    } state_t;

    // Pulse counter counts down from PULSE_CYCLES-1 to 0 while a button is low.
    localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);
    localparam logic [3:0] MAX_D      = 4'(MAX_DIGIT);
    // Bit order {timer_running, start_bt, enter_bt}; buttons idle high, timer idle low.
    localparam logic [2:0] SYNC_IDLE  = 3'b011;

    logic [2:0] sync1_q, sync1_d;
    logic [2:0] sync2_q, sync2_d;
    logic [2:0] prev_q,  prev_d;
    logic [2:0] fall;
    logic       enter_press;
    logic       start_press;
    logic       run_fall;
    logic       run_level;
    logic       digit_ok;

    state_t     state_q,   state_d;
    logic [7:0] cnt_q,     cnt_d;
    logic [3:0] dec_q,     dec_d;
    logic [3:0] sec_q,     sec_d;
    logic       cfg_bt_q,  cfg_bt_d;
    logic       game_bt_q, game_bt_d;
    logic       err_q,     err_d;
    logic       exp_q,     exp_d;

    // Synchronizer chain inputs plus one extra stage for edge detection.
    always_comb begin
        sync1_d = {timer_running, start_bt, enter_bt};
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Synchronizer and edge-detect registers.
    always_ff @(posedge clk_50Mhz or posedge reset) begin
        if (reset) begin
            sync1_q <= SYNC_IDLE;
            sync2_q <= SYNC_IDLE;
            prev_q  <= SYNC_IDLE;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    // 1->0 transitions of the synchronized signals are the events the FSM sees.
    assign fall        = prev_q & ~sync2_q;
    assign enter_press = fall[0];
    assign start_press = fall[1];
    assign run_fall    = fall[2];
    assign run_level   = sync2_q[2];
    assign digit_ok    = (digit_sw <= MAX_D);

    // Next-state and output logic; enter always wins over start.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dec_d     = dec_q;
        sec_d     = sec_q;
        cfg_bt_d  = cfg_bt_q;
        game_bt_d = game_bt_q;
        err_d     = err_q;
        exp_d     = exp_q;
        case (state_q)
            ST_ENTER_DEC: begin
                if (enter_press) begin
                    if (digit_ok) begin
                        dec_d   = digit_sw;
                        err_d   = 1'b0;
                        state_d = ST_ENTER_SEC;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ENTER_SEC: begin
                if (enter_press) begin
                    if (digit_ok) begin
                        sec_d    = digit_sw;
                        err_d    = 1'b0;
                        state_d  = ST_LOAD;
                        cfg_bt_d = 1'b0;
                        cnt_d    = PULSE_LAST;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                // Pulse runs while config_bt is low; one high cycle before ARMED.
                if (!cfg_bt_q) begin
                    if (cnt_q == 8'd0) begin
                        cfg_bt_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (enter_press) begin
                    state_d = ST_ENTER_DEC;
                end else if (start_press) begin
                    state_d   = ST_START;
                    game_bt_d = 1'b0;
                    cnt_d     = PULSE_LAST;
                end
            end
            ST_START: begin
                if (cnt_q == 8'd0) begin
                    game_bt_d = 1'b1;
                    state_d   = ST_WAIT_RUN;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_WAIT_RUN: begin
                if (enter_press) begin
                    state_d = ST_ENTER_DEC;
                end else if (run_level) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                // Digits from the timer are stable when it stops, so sample them directly.
                if (run_fall) begin
                    if ((timer_dec == 4'd0) && (timer_sec == 4'd0)) begin
                        exp_d   = 1'b1;
                        state_d = ST_EXPIRED;
                    end else begin
                        exp_d   = 1'b0;
                        state_d = ST_ARMED;
                    end
                end
            end
            ST_EXPIRED: begin
                if (enter_press) begin
                    exp_d   = 1'b0;
                    state_d = ST_ENTER_DEC;
                end else if (start_press) begin
                    exp_d    = 1'b0;
                    state_d  = ST_LOAD;
                    cfg_bt_d = 1'b0;
                    cnt_d    = PULSE_LAST;
                end
            end
            default: begin
                state_d = ST_ENTER_DEC;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk_50Mhz or posedge reset) begin
        if (reset) begin
            state_q   <= ST_ENTER_DEC;
            cnt_q     <= 8'd0;
            dec_q     <= 4'd9;
            sec_q     <= 4'd9;
            cfg_bt_q  <= 1'b1;
            game_bt_q <= 1'b1;
            err_q     <= 1'b0;
            exp_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dec_q     <= dec_d;
            sec_q     <= sec_d;
            cfg_bt_q  <= cfg_bt_d;
            game_bt_q <= game_bt_d;
            err_q     <= err_d;
            exp_q     <= exp_d;
        end
    end

    assign config_dec = dec_q;
    assign config_sec = sec_q;
    assign config_bt  = cfg_bt_q;
    assign game_bt    = game_bt_q;
    assign state_code = state_q;
    assign digit_err  = err_q;
    assign expired    = exp_q;

endmodule

// File: tb/tb_timer_config_loader.sv
// Testbench for timer_config_loader: directed scenarios followed by random
// operations, each checked against a transaction-level model of the controller.
module tb_timer_config_loader;

    localparam int PULSE  = 4;
    localparam int SETTLE = 16;

    // Model state numbering follows the externally visible state_code values.
    localparam int S_DEC = 0, S_SEC = 1, S_ARMED = 3, S_WAIT = 5, S_RUN = 6, S_EXP = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] digit_sw = 4'd0;
    logic       enter_bt = 1'b1;
    logic       start_bt = 1'b1;
    logic [3:0] timer_dec = 4'd0;
    logic [3:0] timer_sec = 4'd0;
    logic       timer_running = 1'b0;
    logic [3:0] config_dec, config_sec;
    logic       config_bt, game_bt;
    logic [2:0] state_code;
    logic       digit_err, expired;

    int checks = 0;
    int errors = 0;

    // Model
    int m_state, m_dec, m_sec, m_err, m_exp, m_cfg, m_game;

    // Monitor bookkeeping
    int cfg_run = 0, game_run = 0, cfg_pulses = 0, game_pulses = 0;
    int overlap = 0, unstable = 0, cfg_dec0 = 0, cfg_sec0 = 0;
    int last_state = 0;
    int state_log[$];

    timer_config_loader #(.PULSE_CYCLES(PULSE), .MAX_DIGIT(9)) dut (
        .clk_50Mhz    (clk),
        .reset        (reset),
        .digit_sw     (digit_sw),
        .enter_bt     (enter_bt),
        .start_bt     (start_bt),
        .timer_dec    (timer_dec),
        .timer_sec    (timer_sec),
        .timer_running(timer_running),
        .config_dec   (config_dec),
        .config_sec   (config_sec),
        .config_bt    (config_bt),
        .game_bt      (game_bt),
        .state_code   (state_code),
        .digit_err    (digit_err),
        .expired      (expired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse widths, overlap, digit stability and state trace, sampled on negedge.
    always @(negedge clk) begin
        if (reset) begin
            cfg_run  = 0;
            game_run = 0;
        end else begin
            if (!config_bt && !game_bt) overlap++;
            if (!config_bt) begin
                if (cfg_run == 0) begin
                    cfg_dec0 = int'(config_dec);
                    cfg_sec0 = int'(config_sec);
                end else if (int'(config_dec) != cfg_dec0 || int'(config_sec) != cfg_sec0) begin
                    unstable++;
                end
                cfg_run++;
            end else if (cfg_run != 0) begin
                chk("cfg_pulse_len", cfg_run, PULSE);
                cfg_pulses++;
                cfg_run = 0;
            end
            if (!game_bt) begin
                game_run++;
            end else if (game_run != 0) begin
                chk("game_pulse_len", game_run, PULSE);
                game_pulses++;
                game_run = 0;
            end
        end
        if (int'(state_code) != last_state) begin
            state_log.push_back(int'(state_code));
            last_state = int'(state_code);
        end
    end

    task automatic model_reset();
        m_state = S_DEC; m_dec = 9; m_sec = 9; m_err = 0; m_exp = 0;
    endtask

    task automatic model_enter(input int d);
        case (m_state)
            S_DEC: if (d <= 9) begin m_dec = d; m_err = 0; m_state = S_SEC; end else m_err = 1;
            S_SEC: if (d <= 9) begin m_sec = d; m_err = 0; m_state = S_ARMED; m_cfg++; end else m_err = 1;
            S_ARMED, S_WAIT: m_state = S_DEC;
            S_EXP: begin m_exp = 0; m_state = S_DEC; end
            default: ;
        endcase
    endtask

    task automatic model_start();
        case (m_state)
            S_ARMED: begin m_state = S_WAIT; m_game++; end
            S_EXP:   begin m_exp = 0; m_state = S_ARMED; m_cfg++; end
            default: ;
        endcase
    endtask

    task automatic check_model(input string tag);
        chk({tag, ":state"}, int'(state_code), m_state);
        chk({tag, ":dec"}, int'(config_dec), m_dec);
        chk({tag, ":sec"}, int'(config_sec), m_sec);
        chk({tag, ":err"}, int'(digit_err), m_err);
        chk({tag, ":exp"}, int'(expired), m_exp);
        chk({tag, ":cfg_pulses"}, cfg_pulses, m_cfg);
        chk({tag, ":game_pulses"}, game_pulses, m_game);
    endtask

    task automatic press_raw(input logic e, input logic s);
        @(negedge clk);
        enter_bt = ~e;
        start_bt = ~s;
        repeat (2) @(negedge clk);
        enter_bt = 1'b1;
        start_bt = 1'b1;
    endtask

    task automatic settle();
        repeat (SETTLE) @(negedge clk);
    endtask

    task automatic do_enter(input int d);
        digit_sw = 4'(d);
        press_raw(1'b1, 1'b0);
        settle();
        model_enter(d);
        $display("op enter d=%0d state=%0d dec=%0d sec=%0d err=%0d", d, state_code, config_dec, config_sec, digit_err);
        check_model("enter");
    endtask

    task automatic do_start();
        press_raw(1'b0, 1'b1);
        settle();
        model_start();
        $display("op start state=%0d exp=%0d game_pulses=%0d", state_code, expired, game_pulses);
        check_model("start");
    endtask

    task automatic do_both(input int d);
        digit_sw = 4'(d);
        press_raw(1'b1, 1'b1);
        settle();
        model_enter(d);
        $display("op both d=%0d state=%0d", d, state_code);
        check_model("both");
    endtask

    task automatic do_rise();
        @(negedge clk);
        timer_running = 1'b1;
        settle();
        if (m_state == S_WAIT) m_state = S_RUN;
        $display("op run_rise state=%0d", state_code);
        check_model("rise");
    endtask

    task automatic do_fall(input int td, input int ts);
        @(negedge clk);
        timer_dec = 4'(td);
        timer_sec = 4'(ts);
        timer_running = 1'b0;
        settle();
        if (m_state == S_RUN) begin
            if (td == 0 && ts == 0) begin m_state = S_EXP; m_exp = 1; end
            else begin m_state = S_ARMED; m_exp = 0; end
        end
        $display("op run_fall t=%0d%0d state=%0d exp=%0d", td, ts, state_code, expired);
        check_model("fall");
    endtask

    function automatic int rand_digit();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(10, 15));
        return int'($urandom_range(0, 9));
    endfunction

    initial begin
        bit found;
        int r;
        model_reset();
        m_cfg = 0;
        m_game = 0;

        // Reset state
        repeat (4) @(negedge clk);
        check_model("reset");
        chk("reset:config_bt", int'(config_bt), 1);
        chk("reset:game_bt", int'(game_bt), 1);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_model("post_reset");

        // Two valid digits load and arm; trace 0 -> 1 -> 2 -> 3
        state_log.delete();
        do_enter(4);
        do_enter(7);
        chk("trace_len", state_log.size(), 3);
        for (int i = 0; i < 3 && i < state_log.size(); i++)
            chk("trace_state", state_log[i], i + 1);

        // Simultaneous enter+start in ARMED: enter wins, no game pulse
        do_both(2);

        // Reset during the 2nd cycle of a config pulse
        do_enter(5);
        digit_sw = 4'd6;
        press_raw(1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (!config_bt) found = 1'b1;
        end
        chk("pulse_seen", int'(found), 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midreset:config_bt", int'(config_bt), 1);
        chk("midreset:state", int'(state_code), 0);
        chk("midreset:dec", int'(config_dec), 9);
        chk("midreset:sec", int'(config_sec), 9);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        model_reset();
        settle();
        check_model("after_midreset");

        // Invalid digit rejected, then accepted
        do_enter(12);
        do_enter(3);
        do_enter(8);

        // Start, run, expire at 00 with exact latency
        do_start();
        do_rise();
        @(negedge clk);
        timer_dec = 4'd0;
        timer_sec = 4'd0;
        timer_running = 1'b0;
        repeat (2) @(negedge clk);
        chk("exp_latency:early", int'(expired), 0);
        @(negedge clk);
        chk("exp_latency:third", int'(expired), 1);
        chk("exp_latency:state", int'(state_code), S_EXP);
        m_state = S_EXP;
        m_exp = 1;
        settle();
        check_model("expired");

        // Start from EXPIRED reloads stored digits and arms without starting
        do_start();

        // Random operations
        for (int n = 0; n < 90; n++) begin
            r = int'($urandom_range(0, 9));
            case (m_state)
                S_DEC, S_SEC: begin
                    if (r < 7) do_enter(rand_digit());
                    else if (r < 8) do_start();
                    else do_both(rand_digit());
                end
                S_WAIT: begin
                    if (r < 6) do_rise();
                    else if (r < 8) do_enter(rand_digit());
                    else do_start();
                end
                S_RUN: begin
                    if (r < 7) begin
                        if ($urandom_range(0, 1) == 0) do_fall(0, 0);
                        else do_fall(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
                    end else if (r < 8) do_enter(rand_digit());
                    else do_start();
                end
                default: begin
                    if (r < 4) do_start();
                    else if (r < 7) do_enter(rand_digit());
                    else do_both(rand_digit());
                end
            endcase
        end

        chk("overlap_cycles", overlap, 0);
        chk("unstable_digits", unstable, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
